// File: rtl/msk_sbox_sched.sv
// Feeds an NB-byte masked state through one shared pipelined masked S-box, one byte per
// cycle, and gathers the results in order. Shares are routed only, never recombined.
module msk_sbox_sched #(
  parameter int d        = 2,
  parameter int NB       = 16,
  parameter int SBOX_LAT = 4,
  parameter int TO_SLACK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic [NB*8*d-1:0] in_state,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NB*8*d-1:0] out_state,
  output logic              sb_enable,
  output logic              sb_valid_in,
  output logic              sb_inverse,
  output logic [8*d-1:0]    sb_in,
  input  logic              sb_valid_out,
  input  logic [8*d-1:0]    sb_out,
  input  logic [3:0]        sb_need_rnd,
  output logic              rnd_req,
  output logic [1:0]        o_dbg_state
);

  localparam int BW    = 8 * d;
  localparam int CW    = $clog2(NB + 1);
  localparam int LIMIT = NB + SBOX_LAT + TO_SLACK;
  localparam int TW    = $clog2(LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_FIN} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_fcnt, r_ocnt;
  logic [TW-1:0]    r_cyc;
  logic [NB*BW-1:0] r_in;
  logic [NB*BW-1:0] r_out;
  logic             r_inv, r_err;
  logic             w_busy, w_cap, w_last_cap, w_timeout, w_accept;
  logic [BW-1:0]    w_sb_in;

  // S-box handshake is valid-only: the pipeline never stalls, a byte is presented when
  // sb_valid_in=1, and each sb_valid_out=1 is taken while busy and result slots remain.
  assign w_busy     = (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_cap      = w_busy && sb_valid_out && (r_ocnt != CW'(NB));
  assign w_last_cap = w_cap && (r_ocnt == CW'(NB - 1));
  assign w_timeout  = (r_cyc == TW'(LIMIT - 1)) && !w_last_cap && (r_ocnt != CW'(NB));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FEED;
      S_FEED:  if (r_fcnt == CW'(NB - 1)) w_next = S_DRAIN;
      S_DRAIN: if (w_last_cap || w_timeout) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sb_in = '0;
    for (int k = 0; k < NB; k++) begin
      if (r_fcnt == CW'(k)) w_sb_in = r_in[k*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_ocnt  <= '0;
      r_cyc   <= '0;
      r_in    <= '0;
      r_out   <= '0;
      r_inv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_in   <= in_state;
        r_inv  <= inverse;
        r_err  <= 1'b0;
        r_fcnt <= '0;
        r_ocnt <= '0;
        r_cyc  <= TW'(1);
      end else begin
        if (r_state == S_FEED) r_fcnt <= r_fcnt + 1'b1;
        if (w_busy && (r_cyc != TW'(LIMIT))) r_cyc <= r_cyc + 1'b1;
        if (w_cap) r_ocnt <= r_ocnt + 1'b1;
        if ((r_state == S_DRAIN) && w_timeout) r_err <= 1'b1;
        for (int k = 0; k < NB; k++) begin
          if (w_cap && (r_ocnt == CW'(k))) r_out[k*BW +: BW] <= sb_out;
        end
      end
    end
  end

  assign busy        = w_busy;
  assign done        = (r_state == S_FIN);
  assign err         = r_err;
  assign out_state   = r_out;
  assign sb_enable   = w_busy;
  assign sb_valid_in = (r_state == S_FEED);
  assign sb_inverse  = r_inv;
  assign sb_in       = w_sb_in;
  assign rnd_req     = w_busy && (|sb_need_rnd);
  assign o_dbg_state = r_state;

endmodule
